// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_port
//  Purpose  : Data-side memory responder for the CPU MEM stage. Serves
//             little-endian byte/half/word loads and stores from a byte-lane
//             RAM, plus an MMIO window at FFFF_xxxx holding a console-output
//             FIFO (ready/valid drain), a status register and a cycle counter.
//             Loads are combinational; all state commits on the rising edge.
//  Options  : define DATA_MEM_PORT_CYCLE_EN to build the CYCLE register and
//             its free-running 32-bit counter; otherwise CYCLE reads 0.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef MMD
`define MMD 2:0
`endif
`ifndef MMD_WORD
`define MMD_WORD  3'd0
`endif
`ifndef MMD_HALF
`define MMD_HALF  3'd1
`endif
`ifndef MMD_HALFU
`define MMD_HALFU 3'd2
`endif
`ifndef MMD_BYTE
`define MMD_BYTE  3'd3
`endif
`ifndef MMD_BYTEU
`define MMD_BYTEU 3'd4
`endif

module data_mem_port #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [31:0] dataAddress,
    input  logic [31:0] writeMemData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [`MMD] memMode,
    output logic [31:0] readMemData,
    output logic [7:0]  conTxData,
    output logic        conTxValid,
    input  logic        conTxReady,
    output logic        misaligned
);

    localparam int c_addr_w  = $clog2(DEPTH_WORDS);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                w_is_mmio;
    logic                w_sel_conout;
    logic                w_sel_constat;
    logic                w_sel_cycle;
    logic [c_addr_w-1:0] w_ram_idx;

    assign w_is_mmio     = (dataAddress[31:16] == 16'hFFFF);
    assign w_sel_conout  = w_is_mmio && (dataAddress[15:2] == 14'd0);
    assign w_sel_constat = w_is_mmio && (dataAddress[15:2] == 14'd1);
    assign w_sel_cycle   = w_is_mmio && (dataAddress[15:2] == 14'd2);
    assign w_ram_idx     = dataAddress[c_addr_w+1:2];

    // Access size and extension; unknown mode codes fall back to word
    logic w_sz_word;
    logic w_sz_half;
    logic w_sz_byte;
    logic w_signed;

    // Decode memMode into size and sign-extension controls
    always_comb begin
        w_sz_word = 1'b0;
        w_sz_half = 1'b0;
        w_sz_byte = 1'b0;
        w_signed  = 1'b0;
        case (memMode)
            `MMD_HALF:  begin w_sz_half = 1'b1; w_signed = 1'b1; end
            `MMD_HALFU: begin w_sz_half = 1'b1; end
            `MMD_BYTE:  begin w_sz_byte = 1'b1; w_signed = 1'b1; end
            `MMD_BYTEU: begin w_sz_byte = 1'b1; end
            default:    begin w_sz_word = 1'b1; end
        endcase
    end

    // Only RAM accesses can be misaligned; MMIO is always a full word
    logic w_addr_bad;
    logic w_mis_access;

    assign w_addr_bad   = (w_sz_word && (dataAddress[1:0] != 2'b00)) ||
                          (w_sz_half && dataAddress[0]);
    assign w_mis_access = !w_is_mmio && (memRead || memWrite) && w_addr_bad;

    // ------------------------------------------------------------------
    // RAM (little-endian, byte lanes, contents never reset)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [DEPTH_WORDS];
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_ram_we;
    logic [31:0] w_ram_word;
    logic [31:0] w_shift;
    logic [31:0] w_ram_load;

    assign w_ram_we   = memWrite && !w_is_mmio && !w_addr_bad;
    assign w_ram_word = r_ram[w_ram_idx];
    assign w_shift    = w_ram_word >> {dataAddress[1:0], 3'b000};

    // Lane enables and replicated store data for the addressed lanes
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = writeMemData;
        if (w_sz_half) begin
            w_be    = dataAddress[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{writeMemData[15:0]}};
        end else if (w_sz_byte) begin
            w_be    = 4'b0001 << dataAddress[1:0];
            w_wdata = {4{writeMemData[7:0]}};
        end
    end

    // Commit the enabled byte lanes of a store
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Extract and extend the addressed lane; misaligned loads return 0
    always_comb begin
        w_ram_load = w_ram_word;
        if (w_addr_bad) begin
            w_ram_load = 32'h0;
        end else if (w_sz_half) begin
            w_ram_load = {{16{w_signed & w_shift[15]}}, w_shift[15:0]};
        end else if (w_sz_byte) begin
            w_ram_load = {{24{w_signed & w_shift[7]}}, w_shift[7:0]};
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [7:0]         r_drop;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_full_count);
    assign w_pop      = !w_empty && conTxReady;
    assign w_push_req = memWrite && w_sel_conout;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    assign conTxValid = !w_empty;
    assign conTxData  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

    // FIFO storage write; pointers alone define validity so no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= writeMemData[7:0];
        end
    end

    // FIFO pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 8'h00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky misalignment flag
    // ------------------------------------------------------------------
    // Set on any misaligned RAM access, cleared only by reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            misaligned <= 1'b0;
        end else if (w_mis_access) begin
            misaligned <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] w_cycle_rd;

`ifdef DATA_MEM_PORT_CYCLE_EN
    logic [31:0] r_cycle;

    // Free-running counter; a CYCLE store replaces the increment that edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_cycle <= 32'h0;
        end else if (memWrite && w_sel_cycle) begin
            r_cycle <= writeMemData;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_rd = r_cycle;
`else
    assign w_cycle_rd = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    logic [31:0] w_constat;

    assign w_constat = {8'h00, r_drop, 6'h00, w_empty, w_full, 8'(r_count)};

    // Combinational load result, forced to 0 in reset or with no read
    always_comb begin
        readMemData = 32'h0;
        if (resetN && memRead) begin
            if (w_is_mmio) begin
                if (w_sel_constat) begin
                    readMemData = w_constat;
                end else if (w_sel_cycle) begin
                    readMemData = w_cycle_rd;
                end
            end else begin
                readMemData = w_ram_load;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_port
//  Purpose  : Self-checking bench for data_mem_port: directed vector table,
//             hand-written FIFO/CYCLE/reset sequences and randomized traffic
//             compared against a byte-level behavioural model.
//  Options  : honours DATA_MEM_PORT_CYCLE_EN to match the DUT build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_port;

    localparam int DW = 1024;
    localparam int FD = 8;
    localparam int RAM_BYTES = DW * 4;

    localparam logic [2:0] M_WORD  = 3'd0;
    localparam logic [2:0] M_HALF  = 3'd1;
    localparam logic [2:0] M_HALFU = 3'd2;
    localparam logic [2:0] M_BYTE  = 3'd3;
    localparam logic [2:0] M_BYTEU = 3'd4;

    logic        clk;
    logic        resetN;
    logic [31:0] dataAddress;
    logic [31:0] writeMemData;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  memMode;
    logic [31:0] readMemData;
    logic [7:0]  conTxData;
    logic        conTxValid;
    logic        conTxReady;
    logic        misaligned;

    data_mem_port #(
        .DEPTH_WORDS (DW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .dataAddress  (dataAddress),
        .writeMemData (writeMemData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memMode      (memMode),
        .readMemData  (readMemData),
        .conTxData    (conTxData),
        .conTxValid   (conTxValid),
        .conTxReady   (conTxReady),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0]  mb [RAM_BYTES];
    bit          kn [RAM_BYTES];
    logic [7:0]  q [$];
    int          m_drop;
    logic [31:0] m_cyc;
    bit          m_mis;

    // Values sampled mid-cycle by the last step
    logic [31:0] last_rd;
    logic        last_valid;
    logic [7:0]  last_data;
    logic        last_mis;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [2:0]  m;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int msize(input logic [2:0] m);
        if (m == M_HALF || m == M_HALFU) return 2;
        if (m == M_BYTE || m == M_BYTEU) return 1;
        return 4;
    endfunction

    function automatic bit msigned(input logic [2:0] m);
        return (m == M_HALF) || (m == M_BYTE);
    endfunction

    function automatic bit mmisal(input logic [31:0] a, input logic [2:0] m);
        return (int'(a[1:0]) % msize(m)) != 0;
    endfunction

    function automatic logic [31:0] m_constat();
        logic [31:0] v;
        v = 32'(m_drop) << 16;
        if (q.size() == 0)  v = v | 32'h200;
        if (q.size() == FD) v = v | 32'h100;
        v = v | 32'(q.size());
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_drop = 0;
        m_cyc  = 32'h0;
        m_mis  = 1'b0;
    endtask

    // Expected load value; known=0 when it would touch never-written RAM
    task automatic model_read(input logic [31:0] a, input logic [2:0] m, input logic rd,
                              output logic [31:0] v, output bit known);
        int n;
        int base;
        known = 1'b1;
        v = 32'h0;
        if (!rd) return;
        if (a[31:16] == 16'hFFFF) begin
            case (a[15:2])
                14'd1: v = m_constat();
`ifdef DATA_MEM_PORT_CYCLE_EN
                14'd2: v = m_cyc;
`endif
                default: v = 32'h0;
            endcase
            return;
        end
        if (mmisal(a, m)) return;
        n = msize(m);
        base = int'(a % 32'(RAM_BYTES));
        for (int i = 0; i < n; i++) begin
            if (!kn[base + i]) known = 1'b0;
            v = v | (32'(mb[base + i]) << (8 * i));
        end
        if (msigned(m) && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    endtask

    // Apply the effect of one rising edge to the model
    task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                              input logic wr, input logic [2:0] m, input logic rdy);
        bit mmio;
        bit pop;
        bit full;
        int base;
        mmio = (a[31:16] == 16'hFFFF);
        pop  = (q.size() > 0) && rdy;
        full = (q.size() == FD);
        if (!mmio && (rd || wr)) begin
            if (mmisal(a, m)) begin
                m_mis = 1'b1;
            end else if (wr) begin
                base = int'(a % 32'(RAM_BYTES));
                for (int i = 0; i < msize(m); i++) begin
                    mb[base + i] = wd[8*i +: 8];
                    kn[base + i] = 1'b1;
                end
            end
        end
`ifdef DATA_MEM_PORT_CYCLE_EN
        if (mmio && wr && a[15:2] == 14'd2) m_cyc = wd;
        else m_cyc = m_cyc + 32'd1;
`endif
        if (pop) void'(q.pop_front());
        if (mmio && wr && a[15:2] == 14'd0) begin
            if (full && !pop) begin
                if (m_drop < 255) m_drop++;
            end else begin
                q.push_back(wd[7:0]);
            end
        end
    endtask

    // One bus cycle: drive after an edge, check mid-cycle, advance the model
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [2:0] m, input logic rdy);
        logic [31:0] ev;
        bit kw;
        dataAddress  = a;
        writeMemData = wd;
        memRead      = rd;
        memWrite     = wr;
        memMode      = m;
        conTxReady   = rdy;
        #3;
        last_rd    = readMemData;
        last_valid = conTxValid;
        last_data  = conTxData;
        last_mis   = misaligned;
        model_read(a, m, rd, ev, kw);
        if (kw) chk("readMemData", last_rd, ev);
        chk("conTxValid", 32'(last_valid), 32'(q.size() != 0));
        chk("conTxData", 32'(last_data), (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk("misaligned", 32'(last_mis), 32'(m_mis));
        @(posedge clk);
        model_edge(a, wd, rd, wr, m, rdy);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input logic rdy);
        step(32'hFFFF_0000, {24'h0, b}, 1'b0, 1'b1, M_WORD, rdy);
    endtask

    task automatic idle(input logic rdy);
        step(32'h0, 32'h0, 1'b0, 1'b0, M_WORD, rdy);
    endtask

    task automatic rd_mmio(input logic [31:0] a, input logic rdy);
        step(a, 32'h0, 1'b1, 1'b0, M_WORD, rdy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic        rdy;
        logic [2:0]  m;
        int          k;

        tbl[0]  = '{32'h0000_0100, 32'h8899_AABB, 1'b0, 1'b1, M_WORD,  32'h0000_0000, 1'b0};
        tbl[1]  = '{32'h0000_0101, 32'h0,         1'b1, 1'b0, M_BYTE,  32'hFFFF_FFAA, 1'b0};
        tbl[2]  = '{32'h0000_0101, 32'h0,         1'b1, 1'b0, M_BYTEU, 32'h0000_00AA, 1'b0};
        tbl[3]  = '{32'h0000_0102, 32'h0,         1'b1, 1'b0, M_HALF,  32'hFFFF_8899, 1'b0};
        tbl[4]  = '{32'h0000_0103, 32'hFFFF_FF11, 1'b0, 1'b1, M_BYTE,  32'h0000_0000, 1'b0};
        tbl[5]  = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, M_WORD,  32'h1199_AABB, 1'b0};
        tbl[6]  = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, M_HALFU, 32'h0000_AABB, 1'b0};
        tbl[7]  = '{32'hFFFF_0006, 32'h0,         1'b1, 1'b0, M_BYTE,  32'h0000_0200, 1'b0};
        tbl[8]  = '{32'h0000_0102, 32'hDEAD_BEEF, 1'b0, 1'b1, M_WORD,  32'h0000_0000, 1'b0};
        tbl[9]  = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, M_WORD,  32'h1199_AABB, 1'b1};
        tbl[10] = '{32'h0000_0100, 32'h1234_5678, 1'b1, 1'b1, M_WORD,  32'h1199_AABB, 1'b1};
        tbl[11] = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, M_WORD,  32'h1234_5678, 1'b1};
        tbl[12] = '{32'h0000_0101, 32'h0,         1'b1, 1'b0, M_WORD,  32'h0000_0000, 1'b1};
        tbl[13] = '{32'h0000_0103, 32'h0,         1'b1, 1'b0, M_HALF,  32'h0000_0000, 1'b1};
        tbl[14] = '{32'hFFFF_0000, 32'h0,         1'b1, 1'b0, M_WORD,  32'h0000_0000, 1'b1};
        tbl[15] = '{32'hFFFF_0010, 32'h0,         1'b1, 1'b0, M_WORD,  32'h0000_0000, 1'b1};
        tbl[16] = '{32'h0000_1100, 32'h0,         1'b1, 1'b0, M_WORD,  32'h1234_5678, 1'b1};
        tbl[17] = '{32'h0000_0100, 32'h0,         1'b0, 1'b0, M_WORD,  32'h0000_0000, 1'b1};
        tbl[18] = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, 3'd7,    32'h1234_5678, 1'b1};
        tbl[19] = '{32'h0000_0102, 32'h0,         1'b1, 1'b0, M_HALF,  32'h0000_1234, 1'b1};
        tbl[20] = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, M_BYTE,  32'h0000_0078, 1'b1};
        tbl[21] = '{32'h0000_0102, 32'h0000_F00D, 1'b0, 1'b1, M_HALF,  32'h0000_0000, 1'b1};
        tbl[22] = '{32'h0000_0100, 32'h0,         1'b1, 1'b0, M_WORD,  32'hF00D_5678, 1'b1};

        // Reset state, with a read attempted while reset is held
        resetN       = 1'b0;
        dataAddress  = 32'hFFFF_0004;
        writeMemData = 32'h0;
        memRead      = 1'b1;
        memWrite     = 1'b0;
        memMode      = M_WORD;
        conTxReady   = 1'b0;
        #3;
        chk("rst_readMemData", readMemData, 32'h0);
        chk("rst_conTxValid", 32'(conTxValid), 32'h0);
        chk("rst_conTxData", 32'(conTxData), 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #3;
        resetN = 1'b1;
        model_reset();

        // Counter starts at zero on the first cycle out of reset
        rd_mmio(32'hFFFF_0008, 1'b0);
        chk("cycle_first", last_rd, 32'h0);
        rd_mmio(32'hFFFF_0004, 1'b0);
        chk("constat_reset", last_rd, 32'h0000_0200);

        // Directed RAM / decode vectors
        for (int i = 0; i < 23; i++) begin
            step(tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].wr, tbl[i].m, 1'b0);
            chk($sformatf("vec%0d_rd", i), last_rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_mis", i), 32'(last_mis), 32'(tbl[i].exp_mis));
        end

        // FIFO fill and overflow, then drain
        for (int i = 0; i < 10; i++) push(8'h41 + 8'(i), 1'b0);
        rd_mmio(32'hFFFF_0004, 1'b0);
        chk("constat_full", last_rd, 32'h0002_0108);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk($sformatf("drain%0d", i), 32'(last_data), 32'h41 + 32'(i));
        end
        rd_mmio(32'hFFFF_0004, 1'b0);
        chk("valid_after_drain", 32'(last_valid), 32'h0);
        chk("constat_empty", last_rd, 32'h0002_0200);

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), 1'b0);
        step(32'hFFFF_0000, 32'h5A, 1'b0, 1'b1, M_WORD, 1'b1);
        chk("pp_head", 32'(last_data), 32'h50);
        rd_mmio(32'hFFFF_0004, 1'b0);
        chk("pp_constat", last_rd, 32'h0002_0108);
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk($sformatf("pp_drain%0d", i), 32'(last_data), (i < 7) ? 32'h51 + 32'(i) : 32'h5A);
        end

        // CYCLE load and wrap
        step(32'hFFFF_0008, 32'hFFFF_FFFE, 1'b0, 1'b1, M_WORD, 1'b0);
        rd_mmio(32'hFFFF_0008, 1'b0);
`ifdef DATA_MEM_PORT_CYCLE_EN
        chk("cycle_load", last_rd, 32'hFFFF_FFFE);
`else
        chk("cycle_load", last_rd, 32'h0);
`endif
        rd_mmio(32'hFFFF_0008, 1'b0);
`ifdef DATA_MEM_PORT_CYCLE_EN
        chk("cycle_inc", last_rd, 32'hFFFF_FFFF);
`else
        chk("cycle_inc", last_rd, 32'h0);
`endif
        rd_mmio(32'hFFFF_0008, 1'b0);
        chk("cycle_wrap", last_rd, 32'h0);

        // Randomized traffic against the model
        for (int w = 0; w < 64; w++) step(32'(w * 4), $urandom, 1'b0, 1'b1, M_WORD, 1'b0);
        for (int i = 0; i < 400; i++) begin
            k   = int'($urandom_range(0, 9));
            r   = $urandom;
            wd  = $urandom;
            m   = 3'($urandom_range(0, 7));
            rd  = 1'($urandom_range(0, 1));
            wr  = 1'b0;
            rdy = 1'($urandom_range(0, 1));
            case (k)
                0, 1, 2, 3: begin a = r & 32'h7FFF_F0FF; wr = 1'($urandom_range(0, 1)); end
                4, 5, 6:    begin a = 32'hFFFF_0000 | (r & 32'h3); wr = 1'b1; end
                7:          begin a = 32'hFFFF_0004; rd = 1'b1; end
                8:          begin a = 32'hFFFF_0008; rd = 1'b1; wr = ($urandom_range(0, 7) == 0); end
                default:    begin a = 32'hFFFF_0000 | (r & 32'h0000_FFF0); wr = 1'($urandom_range(0, 1)); end
            endcase
            step(a, wd, rd, wr, m, rdy);
        end

        // Async reset with three bytes queued and flags set
        for (int i = 0; i < FD + 2; i++) idle(1'b1);
        step(32'h0000_0001, 32'h0, 1'b1, 1'b0, M_WORD, 1'b0);
        for (int i = 0; i < 3; i++) push(8'h61 + 8'(i), 1'b0);
        chk("pre_rst_valid", 32'(conTxValid), 32'h1);
        dataAddress = 32'hFFFF_0004;
        memRead     = 1'b1;
        memWrite    = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("arst_conTxValid", 32'(conTxValid), 32'h0);
        chk("arst_conTxData", 32'(conTxData), 32'h0);
        chk("arst_misaligned", 32'(misaligned), 32'h0);
        chk("arst_readMemData", readMemData, 32'h0);
        #1;
        resetN = 1'b1;
        model_reset();
        rd_mmio(32'hFFFF_0008, 1'b0);
        chk("arst_cycle", last_rd, 32'h0);
        rd_mmio(32'hFFFF_0004, 1'b0);
        chk("arst_constat", last_rd, 32'h0000_0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
